// File: rtl/ifu_prefetch_q.sv
// Instruction-fetch front end: credit-limited sequential prefetch into a {pc,ir} FIFO,
// with flush redirect that empties the queue and discards responses still in flight.
module ifu_prefetch_q #(
  parameter int PC_SIZE    = 32,
  parameter int INSTR_SIZE = 32,
  parameter int DEPTH      = 4,
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PC_SIZE-1:0]    pc_rtvec,
  output logic                  ifu_req_valid,
  input  logic                  ifu_req_ready,
  output logic [PC_SIZE-1:0]    ifu_req_pc,
  input  logic                  ifu_rsp_valid,
  output logic                  ifu_rsp_ready,
  input  logic [INSTR_SIZE-1:0] ifu_rsp_instr,
  output logic                  ifu_o_valid,
  input  logic                  ifu_o_ready,
  output logic [INSTR_SIZE-1:0] ifu_o_ir,
  output logic [PC_SIZE-1:0]    ifu_o_pc,
  output logic [CNT_W-1:0]      ifu_o_level,
  input  logic                  pipe_flush_req,
  output logic                  pipe_flush_ack,
  input  logic [PC_SIZE-1:0]    pipe_flush_add_op1,
  input  logic [PC_SIZE-1:0]    pipe_flush_add_op2
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PC_SIZE-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_SIZE-1:0]    rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]      inflight_q, inflight_d;
  logic [CNT_W-1:0]      drop_q, drop_d;
  logic [CNT_W-1:0]      level_q, level_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PC_SIZE-1:0]    pc_mem_q [DEPTH];
  logic [PC_SIZE-1:0]    pc_mem_d [DEPTH];
  logic [INSTR_SIZE-1:0] ir_mem_q [DEPTH];
  logic [INSTR_SIZE-1:0] ir_mem_d [DEPTH];

  logic [PC_SIZE-1:0]    flush_sum;
  logic [PC_SIZE-1:0]    flush_target;
  logic [PC_SIZE-1:0]    rtvec_aligned;
  logic [CNT_W:0]        occupancy;
  logic                  req_fire;
  logic                  push;
  logic                  rsp_drop;
  logic                  pop;

  assign flush_sum     = pipe_flush_add_op1 + pipe_flush_add_op2;
  assign flush_target  = flush_sum & ~PC_SIZE'(3);
  assign rtvec_aligned = pc_rtvec & ~PC_SIZE'(3);

  // Credit counts both outstanding requests and buffered entries, so a response always has a slot.
  assign occupancy     = {1'b0, inflight_q} + {1'b0, level_q};
  assign ifu_req_valid = rst_n & ~pipe_flush_req & (occupancy < (CNT_W+1)'(DEPTH));
  assign ifu_req_pc    = fetch_pc_q;
  assign req_fire      = ifu_req_valid & ifu_req_ready;

  assign ifu_rsp_ready  = 1'b1;
  assign pipe_flush_ack = 1'b1;

  assign rsp_drop = ifu_rsp_valid & (drop_q != '0);
  assign push     = ifu_rsp_valid & (drop_q == '0);

  assign ifu_o_valid = (level_q != '0);
  assign ifu_o_ir    = ir_mem_q[rd_ptr_q];
  assign ifu_o_pc    = pc_mem_q[rd_ptr_q];
  assign ifu_o_level = level_q;
  assign pop         = ifu_o_valid & ifu_o_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    level_d    = level_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pc_mem_d   = pc_mem_q;
    ir_mem_d   = ir_mem_q;

    if (pipe_flush_req) begin
      // Everything issued so far is stale; the response landing this cycle is already consumed.
      fetch_pc_d = flush_target;
      rsp_pc_d   = flush_target;
      inflight_d = inflight_q - CNT_W'(ifu_rsp_valid);
      drop_d     = inflight_q - CNT_W'(ifu_rsp_valid);
      level_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + PC_SIZE'(4);
      end
      inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(ifu_rsp_valid);
      if (rsp_drop) begin
        drop_d = drop_q - CNT_W'(1);
      end
      if (push) begin
        pc_mem_d[wr_ptr_q] = rsp_pc_q;
        ir_mem_d[wr_ptr_q] = ifu_rsp_instr;
        wr_ptr_d           = wr_ptr_q + PTR_W'(1);
        rsp_pc_d           = rsp_pc_q + PC_SIZE'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      level_d = level_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= rtvec_aligned;
      rsp_pc_q   <= rtvec_aligned;
      inflight_q <= '0;
      drop_q     <= '0;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i] <= '0;
        ir_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pc_mem_q   <= pc_mem_d;
      ir_mem_q   <= ir_mem_d;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch_q.sv
// Directed bench for ifu_prefetch_q with an in-order instruction memory model.
module tb_ifu_prefetch_q;

  localparam int PC_SIZE    = 32;
  localparam int INSTR_SIZE = 32;
  localparam int DEPTH      = 4;
  localparam int CNT_W      = $clog2(DEPTH) + 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [PC_SIZE-1:0]    pc_rtvec;
  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [PC_SIZE-1:0]    ifu_req_pc;
  logic                  ifu_rsp_valid = 1'b0;
  logic                  ifu_rsp_ready;
  logic [INSTR_SIZE-1:0] ifu_rsp_instr = '0;
  logic                  ifu_o_valid;
  logic                  ifu_o_ready;
  logic [INSTR_SIZE-1:0] ifu_o_ir;
  logic [PC_SIZE-1:0]    ifu_o_pc;
  logic [CNT_W-1:0]      ifu_o_level;
  logic                  pipe_flush_req;
  logic                  pipe_flush_ack;
  logic [PC_SIZE-1:0]    pipe_flush_add_op1;
  logic [PC_SIZE-1:0]    pipe_flush_add_op2;

  logic                  mem_en;
  logic [31:0]           mem_q[$];
  int                    n_cmp = 0;
  int                    n_err = 0;

  ifu_prefetch_q #(.PC_SIZE(PC_SIZE), .INSTR_SIZE(INSTR_SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pc_rtvec(pc_rtvec),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_pc(ifu_req_pc),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_instr(ifu_rsp_instr),
    .ifu_o_valid(ifu_o_valid), .ifu_o_ready(ifu_o_ready), .ifu_o_ir(ifu_o_ir),
    .ifu_o_pc(ifu_o_pc), .ifu_o_level(ifu_o_level),
    .pipe_flush_req(pipe_flush_req), .pipe_flush_ack(pipe_flush_ack),
    .pipe_flush_add_op1(pipe_flush_add_op1), .pipe_flush_add_op2(pipe_flush_add_op2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // One-cycle in-order memory: a request accepted at an edge is answered in the next cycle.
  always begin
    logic        fire;
    logic        take;
    logic [31:0] addr;
    @(posedge clk);
    fire = ifu_req_valid & ifu_req_ready;
    take = ifu_rsp_valid;
    addr = ifu_req_pc;
    if (!rst_n) begin
      mem_q.delete();
    end else begin
      if (take && mem_q.size() > 0) void'(mem_q.pop_front());
      if (fire) mem_q.push_back(addr);
    end
    #1;
    ifu_rsp_valid = mem_en && (mem_q.size() > 0);
    ifu_rsp_instr = (mem_q.size() > 0) ? imem(mem_q[0]) : '0;
  end

  always @(posedge clk) begin
    if (rst_n && ifu_rsp_valid) begin
      n_cmp++;
      assert (dut.inflight_q != '0)
      else begin
        n_err++;
        $error("FAIL rsp_without_inflight: observed inflight=%0d required nonzero", dut.inflight_q);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int w;
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    rst_n = 1'b0; pc_rtvec = 32'h8000_0002; ifu_req_ready = 1'b1; ifu_o_ready = 1'b1;
    mem_en = 1'b1; pipe_flush_req = 1'b0; pipe_flush_add_op1 = '0; pipe_flush_add_op2 = '0;
    tick(); tick();
    chk("rst_o_valid", 64'(ifu_o_valid), 64'd0);
    chk("rst_level", 64'(ifu_o_level), 64'd0);
    chk("rst_o_pc", 64'(ifu_o_pc), 64'd0);
    chk("rst_o_ir", 64'(ifu_o_ir), 64'd0);
    chk("rst_req_valid", 64'(ifu_req_valid), 64'd0);
    chk("rsp_ready_tied", 64'(ifu_rsp_ready), 64'd1);

    // Streaming from the reset vector, one instruction per cycle
    rst_n = 1'b1; #1;
    chk("t1_req_valid", 64'(ifu_req_valid), 64'd1);
    chk("t1_req_pc0", 64'(ifu_req_pc), 64'h8000_0000);
    tick();
    chk("t1_req_pc1", 64'(ifu_req_pc), 64'h8000_0004);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t1_o_valid", 64'(ifu_o_valid), 64'd1);
      chk("t1_o_pc", 64'(ifu_o_pc), 64'(32'h8000_0000 + 32'(4 * i)));
      chk("t1_o_ir", 64'(ifu_o_ir), 64'(imem(32'h8000_0000 + 32'(4 * i))));
    end

    // Back-pressure from EXU fills the queue and stops fetch
    rst_n = 1'b0; pc_rtvec = 32'h0000_1000; ifu_o_ready = 1'b0;
    tick();
    rst_n = 1'b1; #1;
    chk("t2_req_pc0", 64'(ifu_req_pc), 64'h1000);
    for (int i = 0; i < 5; i++) tick();
    chk("t2_full_req_valid", 64'(ifu_req_valid), 64'd0);
    chk("t2_full_level", 64'(ifu_o_level), 64'd4);
    chk("t2_full_head", 64'(ifu_o_pc), 64'h1000);
    chk("t2_full_req_pc", 64'(ifu_req_pc), 64'h1010);
    tick(); tick();
    chk("t2_hold_level", 64'(ifu_o_level), 64'd4);
    chk("t2_hold_req_valid", 64'(ifu_req_valid), 64'd0);
    ifu_o_ready = 1'b1;
    tick();
    chk("t2_resume_req_valid", 64'(ifu_req_valid), 64'd1);
    chk("t2_resume_req_pc", 64'(ifu_req_pc), 64'h1010);
    for (int i = 0; i < 4; i++) begin
      chk("t2_drain_pc", 64'(ifu_o_pc), 64'(32'h1004 + 32'(4 * i)));
      chk("t2_drain_ir", 64'(ifu_o_ir), 64'(imem(32'h1004 + 32'(4 * i))));
      if (i < 3) tick();
    end

    // Memory stalls the request channel for five cycles
    chk("t5_pre_req_pc", 64'(ifu_req_pc), 64'h101c);
    ifu_req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t5_stall_req_valid", 64'(ifu_req_valid), 64'd1);
      chk("t5_stall_req_pc", 64'(ifu_req_pc), 64'h101c);
    end
    ifu_req_ready = 1'b1;
    tick();
    chk("t5_release_req_pc", 64'(ifu_req_pc), 64'h1020);

    // Flush with three requests outstanding and no responses yet
    rst_n = 1'b0; pc_rtvec = 32'h0000_2000; mem_en = 1'b0;
    tick();
    rst_n = 1'b1; #1;
    tick(); tick(); tick();
    ifu_req_ready = 1'b0;
    chk("t3_pre_req_pc", 64'(ifu_req_pc), 64'h200c);
    chk("t3_pre_level", 64'(ifu_o_level), 64'd0);
    pipe_flush_req = 1'b1; pipe_flush_add_op1 = 32'h100; pipe_flush_add_op2 = 32'h23; #1;
    chk("t3_flush_req_valid", 64'(ifu_req_valid), 64'd0);
    chk("t3_flush_ack", 64'(pipe_flush_ack), 64'd1);
    tick();
    pipe_flush_req = 1'b0; ifu_req_ready = 1'b1; mem_en = 1'b1; #1;
    chk("t3_target_req_valid", 64'(ifu_req_valid), 64'd1);
    chk("t3_target_req_pc", 64'(ifu_req_pc), 64'h120);
    w = 0;
    while (!ifu_o_valid && w < 12) begin tick(); w++; end
    chk("t3_first_valid", 64'(ifu_o_valid), 64'd1);
    chk("t3_first_latency", 64'(w), 64'd5);
    chk("t3_first_pc", 64'(ifu_o_pc), 64'h120);
    chk("t3_first_ir", 64'(ifu_o_ir), 64'(imem(32'h120)));

    // Flush coinciding with a response and a head handshake
    tick(); tick();
    chk("t4_pre_o_valid", 64'(ifu_o_valid), 64'd1);
    chk("t4_pre_o_pc", 64'(ifu_o_pc), 64'h128);
    pipe_flush_req = 1'b1; pipe_flush_add_op1 = 32'h3000; pipe_flush_add_op2 = 32'h5;
    tick();
    pipe_flush_req = 1'b0; #1;
    chk("t4_post_o_valid", 64'(ifu_o_valid), 64'd0);
    chk("t4_post_level", 64'(ifu_o_level), 64'd0);
    chk("t4_post_req_pc", 64'(ifu_req_pc), 64'h3004);
    chk("t4_post_req_valid", 64'(ifu_req_valid), 64'd1);
    w = 0;
    while (!ifu_o_valid && w < 12) begin tick(); w++; end
    chk("t4_first_latency", 64'(w), 64'd2);
    chk("t4_first_pc", 64'(ifu_o_pc), 64'h3004);
    chk("t4_first_ir", 64'(ifu_o_ir), 64'(imem(32'h3004)));

    // Reset while the queue holds entries and a request is outstanding
    ifu_o_ready = 1'b0;
    w = 0;
    while (ifu_o_level != CNT_W'(3) && w < 10) begin tick(); w++; end
    chk("t6_pre_level", 64'(ifu_o_level), 64'd3);
    pc_rtvec = 32'h4000_0001; rst_n = 1'b0;
    tick();
    chk("t6_rst_o_valid", 64'(ifu_o_valid), 64'd0);
    chk("t6_rst_level", 64'(ifu_o_level), 64'd0);
    chk("t6_rst_o_pc", 64'(ifu_o_pc), 64'd0);
    chk("t6_rst_req_valid", 64'(ifu_req_valid), 64'd0);
    rst_n = 1'b1; ifu_o_ready = 1'b1; #1;
    chk("t6_restart_req_valid", 64'(ifu_req_valid), 64'd1);
    chk("t6_restart_req_pc", 64'(ifu_req_pc), 64'h4000_0000);
    w = 0;
    while (!ifu_o_valid && w < 12) begin tick(); w++; end
    chk("t6_first_latency", 64'(w), 64'd2);
    chk("t6_first_pc", 64'(ifu_o_pc), 64'h4000_0000);
    chk("t6_first_ir", 64'(ifu_o_ir), 64'(imem(32'h4000_0000)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
